// File: rtl/conv_pkg.sv
// Shared constants, state encoding and helpers for the 5x5 conv sequencer.
// Geometry defaults match the 28x28 input layer; the top recomputes from its own parameters.
package conv_pkg;

    localparam int KERNEL = 5;
    localparam int N_CH   = 3;
    localparam int TAPS   = KERNEL * KERNEL;
    localparam int N_BIAS = 3;

    localparam int WIDTH_DEF  = 28;
    localparam int HEIGHT_DEF = 28;
    localparam int OUT_W      = WIDTH_DEF - KERNEL + 1;
    localparam int OUT_H      = HEIGHT_DEF - KERNEL + 1;
    localparam int EXP        = OUT_W * OUT_H;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLR    = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_FIN    = 3'd4;

    // Number of full KERNELxKERNEL windows a w x h frame produces.
    function automatic int unsigned win_expect(input int unsigned w, input int unsigned h);
        return (w - KERNEL + 1) * (h - KERNEL + 1);
    endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Bundle of the sequencer's scheduler, memory-read and buffer-stream signals.
// master = the sequencer, slave = the surrounding memories, buffer and scheduler.
interface conv_seq_ctrl_if #(
    parameter int DATA_BIT = 8,
    parameter int ADDR_BIT = 10
);

    // Read ports have no backpressure: a cycle with *_rd=1 is a request for
    // *_addr, and the memory presents *_data exactly one cycle later.
    // start and conv_valid are sampled on every rising clk edge.
    logic                start;
    logic                busy;
    logic                done;
    logic                frame_err;

    logic                img_rd;
    logic [ADDR_BIT-1:0] img_addr;
    logic [DATA_BIT-1:0] img_data;

    logic                wt_rd;
    logic [4:0]          wt_addr;
    logic [11:0]         wt_data;

    logic                b_rd;
    logic [1:0]          b_addr;
    logic [7:0]          b_data;

    logic                conv_rst;
    logic [DATA_BIT-1:0] pix_out;
    logic [3:0]          wt_out_1;
    logic [3:0]          wt_out_2;
    logic [3:0]          wt_out_3;
    logic [7:0]          bias_out;
    logic                conv_valid;
    logic [9:0]          win_cnt;

    logic [2:0]          state_dbg;

    modport master (
        input  start, img_data, wt_data, b_data, conv_valid,
        output busy, done, frame_err,
        output img_rd, img_addr, wt_rd, wt_addr, b_rd, b_addr,
        output conv_rst, pix_out, wt_out_1, wt_out_2, wt_out_3, bias_out,
        output win_cnt, state_dbg
    );

    modport slave (
        output start, img_data, wt_data, b_data, conv_valid,
        input  busy, done, frame_err,
        input  img_rd, img_addr, wt_rd, wt_addr, b_rd, b_addr,
        input  conv_rst, pix_out, wt_out_1, wt_out_2, wt_out_3, bias_out,
        input  win_cnt, state_dbg
    );

endinterface

// File: rtl/conv_rd_gen.sv
// Saturating read-address generator: launch arms a read burst from address 0,
// each enabled cycle advances it, and it stops itself after address LAST.
module conv_rd_gen #(
    parameter int AW   = 10,
    parameter int LAST = 783
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          launch,
    input  logic          en,
    output logic          rd,
    output logic [AW-1:0] addr,
    output logic          vld
);

    localparam logic [AW-1:0] LAST_A = AW'(LAST);

    logic          rd_q,   rd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          vld_q,  vld_d;

    always_comb begin
        rd_d   = rd_q;
        addr_d = addr_q;
        // vld marks the cycle the memory answers the previous request
        vld_d  = rd_q;
        if (launch) begin
            rd_d   = 1'b1;
            addr_d = '0;
        end else if (!en) begin
            rd_d = 1'b0;
        end else if (rd_q) begin
            if (addr_q == LAST_A) begin
                rd_d = 1'b0;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= 1'b0;
            addr_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            addr_q <= addr_d;
            vld_q  <= vld_d;
        end
    end

    assign rd   = rd_q;
    assign addr = addr_q;
    assign vld  = vld_q;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Frame sequencer for the 5x5 conv line-buffer stage: clears the buffer, loads
// taps and biases, streams one raster frame and checks the valid-window count.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int WIDTH     = 28,
    parameter int HEIGHT    = 28,
    parameter int DATA_BIT  = 8,
    parameter int ADDR_BIT  = 10,
    parameter int DRAIN_MAX = 64
) (
    input  logic            clk,
    input  logic            rst,
    conv_seq_ctrl_if.master bus
);

    localparam int                  WIN_EXP    = win_expect(WIDTH, HEIGHT);
    localparam logic [9:0]          EXP_CNT    = 10'(WIN_EXP);
    localparam logic [ADDR_BIT-1:0] LAST_PIX   = ADDR_BIT'(WIDTH * HEIGHT - 1);
    localparam int                  DC_W       = $clog2(DRAIN_MAX + 1);
    localparam logic [DC_W-1:0]     DRAIN_LAST = DC_W'(DRAIN_MAX - 1);

    state_t          state_q,   state_d;
    logic [9:0]      win_cnt_q, win_cnt_d;
    logic            err_q,     err_d;
    logic [DC_W-1:0] drain_q,   drain_d;

    logic                launch;
    logic                adv_en;
    logic                counting;
    logic                img_rd;
    logic [ADDR_BIT-1:0] img_addr;
    logic                pix_vld;
    logic                wt_rd;
    logic [4:0]          wt_addr;
    logic                wt_vld;
    logic                b_rd;
    logic [1:0]          b_addr;
    logic                b_vld;

    assign launch   = (state_q == ST_IDLE) && bus.start;
    assign adv_en   = (state_q == ST_CLR) || (state_q == ST_STREAM);
    assign counting = (state_q != ST_IDLE) && (state_q != ST_CLR);

    conv_rd_gen #(
        .AW   (ADDR_BIT),
        .LAST (WIDTH * HEIGHT - 1)
    ) u_pix_rd (
        .clk    (clk),
        .rst    (rst),
        .launch (launch),
        .en     (adv_en),
        .rd     (img_rd),
        .addr   (img_addr),
        .vld    (pix_vld)
    );

    conv_rd_gen #(
        .AW   (5),
        .LAST (TAPS - 1)
    ) u_wt_rd (
        .clk    (clk),
        .rst    (rst),
        .launch (launch),
        .en     (adv_en),
        .rd     (wt_rd),
        .addr   (wt_addr),
        .vld    (wt_vld)
    );

    conv_rd_gen #(
        .AW   (2),
        .LAST (N_BIAS - 1)
    ) u_b_rd (
        .clk    (clk),
        .rst    (rst),
        .launch (launch),
        .en     (adv_en),
        .rd     (b_rd),
        .addr   (b_addr),
        .vld    (b_vld)
    );

    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        err_d     = err_q;
        drain_d   = drain_q;

        if (counting && bus.conv_valid && (win_cnt_q != 10'h3ff)) begin
            win_cnt_d = win_cnt_q + 10'd1;
        end
        // an overshoot can never be recovered, so flag it as soon as it happens
        if (win_cnt_d > EXP_CNT) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_CLR;
                    win_cnt_d = '0;
                    err_d     = 1'b0;
                end
            end
            ST_CLR: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                drain_d = '0;
                if (img_rd && (img_addr == LAST_PIX)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (win_cnt_q == EXP_CNT) begin
                    state_d = ST_FIN;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = ST_FIN;
                    err_d   = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            win_cnt_q <= '0;
            err_q     <= 1'b0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            err_q     <= err_d;
            drain_q   <= drain_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_FIN);
    assign bus.frame_err = err_q;
    assign bus.conv_rst  = (state_q == ST_IDLE) || (state_q == ST_CLR) || (state_q == ST_FIN);
    assign bus.win_cnt   = win_cnt_q;
    assign bus.state_dbg = state_q;

    assign bus.img_rd   = img_rd;
    assign bus.img_addr = img_addr;
    assign bus.wt_rd    = wt_rd;
    assign bus.wt_addr  = wt_addr;
    assign bus.b_rd     = b_rd;
    assign bus.b_addr   = b_addr;

    // Memory data is forwarded only in the cycle it answers a request.
    assign bus.pix_out  = pix_vld ? bus.img_data      : '0;
    assign bus.wt_out_1 = wt_vld  ? bus.wt_data[3:0]  : 4'd0;
    assign bus.wt_out_2 = wt_vld  ? bus.wt_data[7:4]  : 4'd0;
    assign bus.wt_out_3 = wt_vld  ? bus.wt_data[11:8] : 4'd0;
    assign bus.bias_out = b_vld   ? bus.b_data        : 8'd0;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: random frame data and random valid-window placement,
// checked cycle by cycle against frame timing derived from the frame geometry.
module tb_conv_seq_ctrl;

    localparam int W     = 28;
    localparam int H     = 28;
    localparam int NPIX  = W * H;
    localparam int EXPW  = (W - 5 + 1) * (H - 5 + 1);
    localparam int DMAX  = 64;
    localparam int NTAP  = 25;
    localparam int NBIAS = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_seq_ctrl_if #(.DATA_BIT(8), .ADDR_BIT(10)) bus ();

    conv_seq_ctrl #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .DATA_BIT  (8),
        .ADDR_BIT  (10),
        .DRAIN_MAX (DMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- memories (one-cycle read latency) ----------------
    logic [7:0]  img_mem [1024];
    logic [11:0] wt_mem  [32];
    logic [7:0]  b_mem   [4];

    always @(posedge clk) begin
        if (bus.img_rd) bus.img_data <= img_mem[bus.img_addr];
        if (bus.wt_rd)  bus.wt_data  <= wt_mem[bus.wt_addr];
        if (bus.b_rd)   bus.b_data   <= b_mem[bus.b_addr];
    end

    // ---------------- scoreboard ----------------
    int n_chk = 0;
    int n_bad = 0;
    int frame_id = 0;
    int cur_k = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s frame=%0d k=%0d got=%0h exp=%0h", tag, frame_id, cur_k, got, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check_reset_state();
        check_eq("rst_busy",     bus.busy, 0);
        check_eq("rst_done",     bus.done, 0);
        check_eq("rst_err",      bus.frame_err, 0);
        check_eq("rst_conv_rst", bus.conv_rst, 1);
        check_eq("rst_rd",       {bus.img_rd, bus.wt_rd, bus.b_rd}, 0);
        check_eq("rst_img_addr", bus.img_addr, 0);
        check_eq("rst_wt_addr",  bus.wt_addr, 0);
        check_eq("rst_b_addr",   bus.b_addr, 0);
        check_eq("rst_win_cnt",  bus.win_cnt, 0);
        check_eq("rst_pix",      bus.pix_out, 0);
        check_eq("rst_wt_out",   {bus.wt_out_3, bus.wt_out_2, bus.wt_out_1}, 0);
        check_eq("rst_bias",     bus.bias_out, 0);
    endtask

    // ---------------- driver: one frame ----------------
    // Called right after a falling edge; start is raised in that same cycle (k=0).
    // Expected timing: CLR at k=1, pixel i requested at k=i+1 and presented at
    // k=i+2, DRAIN from k=NPIX+1, FIN one cycle later on an exact count or
    // DMAX cycles later on a timeout.
    task automatic run_frame(input int n_valid, input int mid_start_k,
                             input bit fin_start, input int rst_at);
        logic [7:0] exp_q[$];
        logic       vmap [1024];
        int         need;
        int         cnt;
        int         k_fin;
        bit         timeout;

        frame_id++;
        for (int i = 0; i < NPIX; i++) img_mem[i] = 8'($urandom_range(255, 0));
        for (int i = 0; i < NTAP; i++) wt_mem[i] = 12'($urandom_range(4095, 0));
        for (int i = 0; i < NPIX; i++) exp_q.push_back(img_mem[i]);

        // spread exactly n_valid window pulses over the streaming cycles 2..NPIX
        for (int k = 0; k < 1024; k++) vmap[k] = 1'b0;
        need = n_valid;
        for (int k = 2; k <= NPIX; k++) begin
            if ($urandom_range(NPIX - k, 0) < need) begin
                vmap[k] = 1'b1;
                need--;
            end
        end

        timeout = (n_valid != EXPW);
        k_fin   = timeout ? (NPIX + 1 + DMAX) : (NPIX + 2);
        cnt     = 0;

        cur_k = 0;
        bus.start = 1'b1;
        for (int k = 1; k <= k_fin + 1; k++) begin
            @(negedge clk);
            cur_k = k;
            bus.start      = 1'b0;
            bus.conv_valid = 1'b0;

            if (rst_at != 0 && k == rst_at + 1) begin
                check_reset_state();
                rst = 1'b0;
                return;
            end

            if (vmap[k-1]) cnt++;

            check_eq("busy",     bus.busy, k <= k_fin);
            check_eq("done",     bus.done, k == k_fin);
            check_eq("conv_rst", bus.conv_rst, (k == 1) || (k >= k_fin));
            check_eq("img_rd",   bus.img_rd, k <= NPIX);
            check_eq("img_addr", bus.img_addr, imin(k - 1, NPIX - 1));
            check_eq("wt_rd",    bus.wt_rd, k <= NTAP);
            check_eq("wt_addr",  bus.wt_addr, imin(k - 1, NTAP - 1));
            check_eq("b_rd",     bus.b_rd, k <= NBIAS);
            check_eq("b_addr",   bus.b_addr, imin(k - 1, NBIAS - 1));

            if (k >= 2 && k <= NPIX + 1) check_eq("pix_out", bus.pix_out, exp_q.pop_front());
            else                         check_eq("pix_out", bus.pix_out, 0);

            check_eq("wt_out", {bus.wt_out_3, bus.wt_out_2, bus.wt_out_1},
                     (k >= 2 && k <= NTAP + 1) ? wt_mem[k-2] : 12'd0);
            check_eq("bias_out", bus.bias_out,
                     (k >= 2 && k <= NBIAS + 1) ? b_mem[k-2] : 8'd0);
            check_eq("win_cnt",   bus.win_cnt, cnt);
            check_eq("frame_err", bus.frame_err, (cnt > EXPW) || (timeout && k >= k_fin));

            if (vmap[k])                  bus.conv_valid = 1'b1;
            if (k == mid_start_k)         bus.start = 1'b1;
            if (fin_start && k == k_fin)  bus.start = 1'b1;
            if (k == rst_at)              rst = 1'b1;
        end
        check_eq("final_win_cnt", bus.win_cnt, n_valid);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.conv_valid = 1'b0;
        bus.img_data   = '0;
        bus.wt_data    = '0;
        bus.b_data     = '0;
        b_mem[0] = 8'h11;
        b_mem[1] = 8'h22;
        b_mem[2] = 8'h33;
        b_mem[3] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_busy",     bus.busy, 0);
        check_eq("idle_conv_rst", bus.conv_rst, 1);

        run_frame(EXPW,     0,   1'b0, 0);    // exact count
        run_frame(EXPW - 1, 0,   1'b0, 0);    // one short: drain timeout
        run_frame(EXPW,     101, 1'b0, 0);    // start while streaming is ignored
        run_frame(EXPW,     0,   1'b0, 401);  // reset when img_addr is 400
        run_frame(EXPW,     0,   1'b0, 0);    // restart from address 0
        run_frame(EXPW + 4, 0,   1'b1, 0);    // overshoot; start during FIN ignored
        run_frame(EXPW,     0,   1'b0, 0);    // back-to-back: error and count cleared

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
